// File: rtl/alu_result_bcd.sv
// ALU result to signed BCD converter (double-dabble, one bit per cycle).
// Feeds three BCD digits plus a sign flag to the seven-segment driver.
module alu_result_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sum,
    input  logic       c_8,
    input  logic       alb,
    input  logic       add_sub,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1
    } state_t;

    state_t      r_state;
    logic [8:0]  r_shift;
    logic [11:0] r_scratch;
    logic [3:0]  r_count;
    logic        r_sign;
    logic        r_busy;
    logic        r_done;
    logic        r_neg;
    logic [3:0]  r_hundreds;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    logic [7:0]  w_neg_sum;
    logic [8:0]  w_mag;
    logic        w_sign;
    logic [11:0] w_adj;
    logic [11:0] w_scr_next;
    logic [8:0]  w_shift_next;

    assign w_neg_sum = ~sum + 8'd1;

    // Signed magnitude of the ALU result; a zero magnitude is always positive.
    always_comb begin
        w_mag  = {c_8, sum};
        w_sign = 1'b0;
        if (add_sub) begin
            if (alb) begin
                w_mag  = {1'b0, w_neg_sum};
                w_sign = 1'b1;
            end else begin
                w_mag  = {1'b0, sum};
            end
        end
        if (w_mag == 9'd0) begin
            w_sign = 1'b0;
        end
    end

    // Add-3 correction on every scratch nibble that is 5 or more.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
            end
        end
        w_scr_next   = {w_adj[10:0], r_shift[8]};
        w_shift_next = {r_shift[7:0], 1'b0};
    end

    // Conversion FSM with registered status and digit outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= 9'd0;
            r_scratch  <= 12'd0;
            r_count    <= 4'd0;
            r_sign     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_neg      <= 1'b0;
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= w_mag;
                        r_scratch <= 12'd0;
                        r_count   <= 4'd0;
                        r_sign    <= w_sign;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_scratch <= w_scr_next;
                    r_shift   <= w_shift_next;
                    r_count   <= r_count + 4'd1;
                    if (r_count == 4'd8) begin
                        r_hundreds <= w_scr_next[11:8];
                        r_tens     <= w_scr_next[7:4];
                        r_ones     <= w_scr_next[3:0];
                        r_neg      <= r_sign;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign neg      = r_neg;
    assign hundreds = r_hundreds;
    assign tens     = r_tens;
    assign ones     = r_ones;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Bench for alu_result_bcd: arithmetic reference model checked every cycle,
// plus directed conversions with hand-computed digits.
module tb_alu_result_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] sum = 8'd0;
    logic       c_8 = 1'b0;
    logic       alb = 1'b0;
    logic       add_sub = 1'b0;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    int vectors = 0;
    int miscompares = 0;

    alu_result_bcd dut (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .c_8(c_8),
        .alb(alb), .add_sub(add_sub), .busy(busy), .done(done),
        .neg(neg), .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    // Reference model: value-level arithmetic plus a cycle countdown.
    int   m_cnt = 0;
    logic m_busy = 0, m_done = 0, m_neg = 0;
    int   m_val = 0, p_val = 0;
    logic p_neg = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_busy = 0; m_done = 0;
            m_neg = 0; m_val = 0;
        end else begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (start) begin
                    if (!add_sub) begin
                        p_val = int'(c_8) * 256 + int'(sum);
                        p_neg = 0;
                    end else if (alb) begin
                        p_val = (256 - int'(sum)) % 256;
                        p_neg = (p_val != 0);
                    end else begin
                        p_val = int'(sum);
                        p_neg = 0;
                    end
                    m_cnt = 9;
                    m_busy = 1;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_val = p_val;
                    m_neg = p_neg;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (busy !== m_busy || done !== m_done || neg !== m_neg ||
                hundreds !== 4'(m_val / 100) ||
                tens !== 4'((m_val / 10) % 10) ||
                ones !== 4'(m_val % 10)) begin
                miscompares++;
                $display("FAIL model t=%0t got b%0b d%0b n%0b %0d%0d%0d req b%0b d%0b n%0b %0d",
                         $time, busy, done, neg, hundreds, tens, ones,
                         m_busy, m_done, m_neg, m_val);
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic conv(input string name, input logic as, input logic [7:0] s,
                        input logic c, input logic a, input int eh,
                        input int et, input int eo, input int en);
        int n;
        @(negedge clk);
        add_sub = as; sum = s; c_8 = c; alb = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sum = ~s; c_8 = ~c; alb = ~a; add_sub = ~as;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, 9);
        chk({name, "_h"}, int'(hundreds), eh);
        chk({name, "_t"}, int'(tens), et);
        chk({name, "_o"}, int'(ones), eo);
        chk({name, "_neg"}, int'(neg), en);
        @(negedge clk);
    endtask

    initial begin
        int dn;
        int last;
        int gap_bad;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_digits", int'({hundreds, tens, ones}), 0);
        rst = 1'b0;
        @(negedge clk);

        conv("add_125", 0, 8'h7D, 0, 0, 1, 2, 5, 0);
        conv("sub_m1", 1, 8'hFF, 0, 1, 0, 0, 1, 1);
        conv("sub_p1", 1, 8'h01, 0, 0, 0, 0, 1, 0);
        conv("add_510", 0, 8'hFE, 1, 0, 5, 1, 0, 0);
        conv("add_0", 0, 8'h00, 0, 0, 0, 0, 0, 0);
        conv("sub_m128", 1, 8'h80, 0, 1, 1, 2, 8, 1);
        conv("sub_zero", 1, 8'h00, 0, 1, 0, 0, 0, 0);
        conv("sub_m255", 1, 8'h01, 0, 1, 2, 5, 5, 1);

        // Start re-asserted mid-conversion must be ignored.
        @(negedge clk);
        add_sub = 0; sum = 8'h7D; c_8 = 0; alb = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        add_sub = 1; sum = 8'h80; alb = 1; start = 1;
        @(negedge clk);
        start = 0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("ign_dones", dn, 1);
        chk("ign_val", int'(hundreds) * 100 + int'(tens) * 10 + int'(ones), 125);
        chk("ign_neg", int'(neg), 0);

        // Start held high: done every 10 cycles.
        @(negedge clk);
        add_sub = 0; sum = 8'h7D; c_8 = 0; alb = 0; start = 1;
        dn = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 42; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (last >= 0 && i - last != 10) gap_bad++;
                last = i;
                dn++;
            end
        end
        @(negedge clk);
        start = 0;
        chk("held_dones", dn, 4);
        chk("held_gap", gap_bad, 0);
        repeat (12) @(negedge clk);

        // Reset at cycle 4 of a conversion aborts it.
        add_sub = 1; sum = 8'hFF; alb = 1; c_8 = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_digits", int'({hundreds, tens, ones}), 0);
        chk("arst_neg", int'(neg), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("arst_nodone", dn, 0);
        conv("post_rst", 0, 8'h2A, 1, 0, 2, 9, 8, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
